wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order MEM/WB writeback and a long-latency unit (LU: multiplier/divider or slow load path) that finishes out of order.
- The pipeline always has priority.
- LU results with no free write slot are queued in a small FIFO and drained in idle writeback cycles.
- A starvation counter forces a one-cycle pipeline stall so that queued results cannot wait indefinitely.
- The block exposes a pending-register mask to the hazard unit.

Parameters:
DEPTH, 2, LU result FIFO entries (power of 2, >=2)
MAX_WAIT, 4, consecutive cycles a non-empty FIFO may go without a pop before stall_o is forced (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pipe_RegWrite_i  in  1  MEM/WB writeback enable
pipe_wr_i  in  5  MEM/WB destination register
pipe_wdata_i  in  32  MEM/WB writeback data (already MemToReg-selected)
lu_valid_i  in  1  LU result valid
lu_wr_i  in  5  LU destination register
lu_wdata_i  in  32  LU result data
lu_ready_o  out  1  block accepts LU result this cycle
rf_we_o  out  1  register-file write enable
rf_wr_o  out  5  register-file write address
rf_wdata_o  out  32  register-file write data
stall_o  out  1  pipeline must freeze MEM/WB and re-present its inputs next cycle
pend_o  out  32  bit n=1 while any FIFO entry targets xn

Behaviour:
- State: FIFO storage {wr, data} x DEPTH; rd_ptr/wr_ptr; count (clog2(DEPTH)+1 bits); wait_cnt (clog2(MAX_WAIT+1) bits); stall_o register.
- Reset (rst=1 at an edge):
  - count, pointers, wait_cnt and stall_o are cleared to 0; queued entries are discarded.
  - While rst=1, rf_we_o is forced to 0.
  - After reset: lu_ready_o=1, pend_o=0, rf_we_o=0.
- Qualifiers:
  - pipe_req = pipe_RegWrite_i & (pipe_wr_i!=0) & !stall_o. While stall_o=1, pipeline inputs are ignored.
  - lu_acc = lu_valid_i & lu_ready_o.
  - lu_ready_o = (count != DEPTH). It is derived from registered count only; a pop in the same cycle does not free a slot.
- Write-port grant, combinational and evaluated in this order:
  1. pipe_req: rf <= pipeline inputs.
  2. else if count!=0: pop FIFO head to rf.
  3. else if lu_acc & lu_wr_i!=0: bypass the LU directly to rf (zero latency, not queued).
  4. else rf_we_o=0. rf_wr_o and rf_wdata_o are don't-care, driven 0.
- Push:
  - lu_acc & lu_wr_i!=0 & not bypassed: enqueue at the next edge.
  - lu_acc with lu_wr_i==0: accepted and discarded, with no queue entry and no RF write.
- Simultaneous push and pop: both happen, and count is unchanged.
- FIFO order is strict; queued entries never reorder among themselves.
- Starvation counter and stall:
  - wait_cnt increments each cycle count!=0 and no pop occurs.
  - wait_cnt clears on any pop or when count==0.
  - stall_o is registered: stall_o_next = (wait_cnt_next == MAX_WAIT).
  - While stall_o=1, pipe_req=0, so the head is popped. wait_cnt then returns to 0 and stall_o deasserts the following cycle, giving exactly one bubble.
- pend_o: OR of one-hot(wr) over valid FIFO entries; combinational from registered state. Bypassed writes never appear in pend_o.
- The hazard unit must not issue a younger writer/reader of a register whose pend_o bit is set. This block does not check WAW between the pipeline and the FIFO.
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package (cpu_pkg):
  - REG_ADDR_W=5, XLEN=32
  - wb_entry_t struct {wr, data}
- Natural sub-module: wb_fifo. It is a sync FIFO, parameterised on DEPTH/width, with full, empty and count outputs, plus a flat entry-view port used to build pend_o.
- The arbiter, starvation counter and pend mask stay in wb_port_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with pipe_RegWrite_i=1, lu_valid_i=1 -> rf_we_o=0, stall_o=0, lu_ready_o=1, pend_o=0; after release, FIFO is empty.
- Bypass: FIFO empty, pipe idle, LU x5=0xDEADBEEF -> same cycle rf_we_o=1, rf_wr_o=5, rf_wdata_o=0xDEADBEEF; pend_o stays 0.
- Priority/queue: pipe x3=0x11 and LU x7=0x22 in the same cycle -> RF writes x3=0x11. Next cycle, with pipe idle, RF writes x7=0x22; pend_o[7]=1 for exactly that one cycle.
- Full/backpressure (DEPTH=2): pipe writes every cycle, LU pushes x8 then x9 -> lu_ready_o=0 from the following cycle; a third LU result (x10) is held until a pop occurs, and lu_ready_o returns 1 the cycle after that pop.
- Starvation (MAX_WAIT=4): pipe writes every cycle, LU x9=0x55 queued at edge t0 -> stall_o=1 exactly in cycle t0+5, with RF x9=0x55 that cycle and the pipe write ignored; stall_o=0 at t0+6, when the re-presented pipe write is performed.
- x0 and reset mid-operation: LU wr=0 -> no RF write, count unchanged. With 2 entries queued, assert rst for 1 cycle -> pend_o=0, lu_ready_o=1, and no stale entry is ever written.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   wb_entry_t : one queued writeback {wr, data}; wr sits in the MSBs
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus between the MEM/WB stage, the long-latency unit, the register file and
// the hazard unit on one side, and the writeback arbiter on the other.
//   pipe_*     : in-order writeback request
//   lu_*       : long-latency unit result with ready handshake
//   rf_*       : register-file write port
//   stall_o    : pipeline freeze request
//   pend_o     : registers with a queued (not yet written) result
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  pipe_RegWrite_i;
    logic [REG_ADDR_W-1:0] pipe_wr_i;
    logic [XLEN-1:0]       pipe_wdata_i;
    logic                  lu_valid_i;
    logic [REG_ADDR_W-1:0] lu_wr_i;
    logic [XLEN-1:0]       lu_wdata_i;
    logic                  lu_ready_o;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_wr_o;
    logic [XLEN-1:0]       rf_wdata_o;
    logic                  stall_o;
    logic [XLEN-1:0]       pend_o;

    // Driver side: pipeline, LU, register file and hazard unit.
    modport master (
        output pipe_RegWrite_i, pipe_wr_i, pipe_wdata_i,
        output lu_valid_i, lu_wr_i, lu_wdata_i,
        input  lu_ready_o, rf_we_o, rf_wr_o, rf_wdata_o, stall_o, pend_o
    );

    // Arbiter side.
    modport slave (
        input  pipe_RegWrite_i, pipe_wr_i, pipe_wdata_i,
        input  lu_valid_i, lu_wr_i, lu_wdata_i,
        output lu_ready_o, rf_we_o, rf_wr_o, rf_wdata_o, stall_o, pend_o
    );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Synchronous FIFO holding deferred LU results.
//   clk, rst      : clock, synchronous active-high reset (drops all entries)
//   push, wdata   : enqueue (ignored when full)
//   pop, rdata    : dequeue / head entry (ignored when empty)
//   full, empty   : occupancy flags
//   count         : number of valid entries
//   valid, tags   : per-slot valid bit and tag field (top TAG_W bits of the entry)
module wb_port_arbiter_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned TAG_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         valid,
    output logic [DEPTH*TAG_W-1:0]   tags
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        valid = '0;
        tags  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]               = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
            tags[i*TAG_W +: TAG_W] = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order MEM/WB writeback and
// an out-of-order long-latency unit (LU).
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_port_arbiter_if slave (pipe/LU inputs, RF port, stall, pend)
// Pipeline wins the port; LU results that lose are queued and drained in idle
// writeback cycles. A queue that goes MAX_WAIT cycles without a pop forces a
// single-cycle pipeline stall so the head gets written.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    wb_entry_t                   lu_entry, head;
    logic                        full, empty;
    logic [CW-1:0]               count;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH*REG_ADDR_W-1:0] tags;

    logic pipe_req, lu_acc, lu_wr_nz, pop, bypass, push;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q;

    // While stalled the pipeline re-presents its inputs, so they are ignored.
    assign pipe_req = bus.pipe_RegWrite_i & (bus.pipe_wr_i != '0) & ~stall_q;
    assign lu_acc   = bus.lu_valid_i & ~full;
    assign lu_wr_nz = lu_acc & (bus.lu_wr_i != '0);
    assign pop      = ~pipe_req & ~empty;
    assign bypass   = ~pipe_req & empty & lu_wr_nz;
    assign push     = lu_wr_nz & ~bypass;

    assign lu_entry.wr   = bus.lu_wr_i;
    assign lu_entry.data = bus.lu_wdata_i;

    wb_port_arbiter_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (REG_ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (lu_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count),
        .valid (valid),
        .tags  (tags)
    );

    // Ready comes from registered occupancy only; a same-cycle pop frees nothing.
    assign bus.lu_ready_o = ~full;
    assign bus.stall_o    = stall_q;

    always_comb begin
        bus.rf_we_o    = 1'b0;
        bus.rf_wr_o    = '0;
        bus.rf_wdata_o = '0;
        if (pipe_req) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_wr_o    = bus.pipe_wr_i;
            bus.rf_wdata_o = bus.pipe_wdata_i;
        end else if (pop) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_wr_o    = head.wr;
            bus.rf_wdata_o = head.data;
        end else if (bypass) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_wr_o    = bus.lu_wr_i;
            bus.rf_wdata_o = bus.lu_wdata_i;
        end
        if (rst) bus.rf_we_o = 1'b0;
    end

    always_comb begin
        bus.pend_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) bus.pend_o[tags[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
        end
    end

    // Starvation: count cycles the queue sits non-empty without a pop.
    assign wait_d = ((count != '0) && !pop) ? wait_q + WW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= (wait_d == WW'(MAX_WAIT));
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    wb_entry_t mq[$];
    int        m_starve;
    bit        m_stall;
    bit        model_valid = 1'b0;

    int        u_n;
    bit        u_pipe_ok, u_served, u_took;
    wb_entry_t u_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_starve    = 0;
            m_stall     = 1'b0;
            model_valid = 1'b1;
        end else begin
            u_n       = mq.size();
            u_pipe_ok = bus.pipe_RegWrite_i && (bus.pipe_wr_i != 0) && !m_stall;
            u_served  = !u_pipe_ok && (u_n > 0);
            u_took    = bus.lu_valid_i && (u_n < DEPTH) && (bus.lu_wr_i != 0);
            if (u_served) void'(mq.pop_front());
            // The LU result is queued only when the port was busy or the queue non-empty.
            if (u_took && (u_pipe_ok || u_n > 0)) begin
                u_e.wr   = bus.lu_wr_i;
                u_e.data = bus.lu_wdata_i;
                mq.push_back(u_e);
            end
            m_starve = (u_n > 0 && !u_served) ? m_starve + 1 : 0;
            m_stall  = (m_starve == MAX_WAIT);
        end
    end

    int          c_n;
    bit          c_pipe_ok, c_we, c_ready;
    logic [4:0]  c_wr;
    logic [31:0] c_wd, c_pend;

    always @(negedge clk) begin
        if (model_valid) begin
            c_n       = mq.size();
            c_ready   = (c_n < DEPTH);
            c_pipe_ok = bus.pipe_RegWrite_i && (bus.pipe_wr_i != 0) && !m_stall;
            c_we      = 1'b1;
            c_wr      = '0;
            c_wd      = '0;
            if (c_pipe_ok) begin
                c_wr = bus.pipe_wr_i;
                c_wd = bus.pipe_wdata_i;
            end else if (c_n > 0) begin
                c_wr = mq[0].wr;
                c_wd = mq[0].data;
            end else if (bus.lu_valid_i && c_ready && bus.lu_wr_i != 0) begin
                c_wr = bus.lu_wr_i;
                c_wd = bus.lu_wdata_i;
            end else begin
                c_we = 1'b0;
            end
            if (rst) c_we = 1'b0;
            c_pend = '0;
            foreach (mq[i]) c_pend[mq[i].wr] = 1'b1;

            check("model rf_we", 32'(bus.rf_we_o), 32'(c_we));
            if (c_we) begin
                check("model rf_wr", 32'(bus.rf_wr_o), 32'(c_wr));
                check("model rf_wdata", bus.rf_wdata_o, c_wd);
            end
            check("model stall", 32'(bus.stall_o), 32'(m_stall));
            check("model lu_ready", 32'(bus.lu_ready_o), 32'(c_ready));
            check("model pend", bus.pend_o, c_pend);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] wr, input logic [31:0] d);
        bus.pipe_RegWrite_i = we;
        bus.pipe_wr_i       = wr;
        bus.pipe_wdata_i    = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] wr, input logic [31:0] d);
        bus.lu_valid_i = v;
        bus.lu_wr_i    = wr;
        bus.lu_wdata_i = d;
    endtask

    initial begin
        rst = 1'b1;
        set_pipe(1'b1, 5'd3, 32'hAAAA);
        set_lu(1'b1, 5'd4, 32'hBBBB);
        cyc();
        cyc();
        @(negedge clk);
        check("reset rf_we", 32'(bus.rf_we_o), 32'd0);
        check("reset stall", 32'(bus.stall_o), 32'd0);
        check("reset lu_ready", 32'(bus.lu_ready_o), 32'd1);
        check("reset pend", bus.pend_o, 32'd0);

        cyc();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("post-reset rf_we", 32'(bus.rf_we_o), 32'd0);
        check("post-reset lu_ready", 32'(bus.lu_ready_o), 32'd1);

        // Bypass
        cyc();
        set_lu(1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("bypass rf_we", 32'(bus.rf_we_o), 32'd1);
        check("bypass rf_wr", 32'(bus.rf_wr_o), 32'd5);
        check("bypass rf_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        check("bypass pend", bus.pend_o, 32'd0);

        // Priority / queue
        cyc();
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd7, 32'h22);
        @(negedge clk);
        check("prio rf_wr", 32'(bus.rf_wr_o), 32'd3);
        check("prio rf_wdata", bus.rf_wdata_o, 32'h11);
        cyc();
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("drain rf_wr", 32'(bus.rf_wr_o), 32'd7);
        check("drain rf_wdata", bus.rf_wdata_o, 32'h22);
        check("drain pend", bus.pend_o, 32'h80);
        cyc();
        @(negedge clk);
        check("drained pend", bus.pend_o, 32'd0);

        // LU write to x0 is swallowed
        cyc();
        set_lu(1'b1, 5'd0, 32'h99);
        @(negedge clk);
        check("x0 rf_we", 32'(bus.rf_we_o), 32'd0);
        cyc();
        set_lu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("x0 pend", bus.pend_o, 32'd0);

        // Backpressure and starvation: pipe writes every cycle
        cyc();                                   // A
        set_pipe(1'b1, 5'd2, 32'h202);
        set_lu(1'b1, 5'd8, 32'h88);
        cyc();                                   // B
        set_lu(1'b1, 5'd9, 32'h99);
        @(negedge clk);
        check("fill lu_ready B", 32'(bus.lu_ready_o), 32'd1);
        check("fill pend B", bus.pend_o, 32'h100);
        cyc();                                   // C
        set_lu(1'b1, 5'd10, 32'hAA);
        @(negedge clk);
        check("full lu_ready C", 32'(bus.lu_ready_o), 32'd0);
        check("full pend C", bus.pend_o, 32'h300);
        check("full rf_wr C", 32'(bus.rf_wr_o), 32'd2);
        cyc();                                   // D
        cyc();                                   // E
        @(negedge clk);
        check("starve stall E", 32'(bus.stall_o), 32'd0);
        cyc();                                   // F
        @(negedge clk);
        check("starve stall F", 32'(bus.stall_o), 32'd1);
        check("starve rf_wr F", 32'(bus.rf_wr_o), 32'd8);
        check("starve rf_wdata F", bus.rf_wdata_o, 32'h88);
        check("starve lu_ready F", 32'(bus.lu_ready_o), 32'd0);
        cyc();                                   // G
        @(negedge clk);
        check("unstall stall G", 32'(bus.stall_o), 32'd0);
        check("unstall lu_ready G", 32'(bus.lu_ready_o), 32'd1);
        check("unstall rf_wr G", 32'(bus.rf_wr_o), 32'd2);
        cyc();                                   // H
        set_lu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("queued pend H", bus.pend_o, 32'h600);
        check("queued lu_ready H", 32'(bus.lu_ready_o), 32'd0);

        // Reset mid-operation with two entries queued
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("midrst rf_we", 32'(bus.rf_we_o), 32'd0);
        cyc();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("midrst pend", bus.pend_o, 32'd0);
        check("midrst lu_ready", 32'(bus.lu_ready_o), 32'd1);
        check("midrst rf_we", 32'(bus.rf_we_o), 32'd0);
        cyc();
        @(negedge clk);
        check("midrst stale rf_we", 32'(bus.rf_we_o), 32'd0);

        // Simultaneous push and pop
        cyc();
        set_pipe(1'b1, 5'd2, 32'h202);
        set_lu(1'b1, 5'd11, 32'hB1);
        cyc();
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b1, 5'd12, 32'hC2);
        @(negedge clk);
        check("pushpop rf_wr", 32'(bus.rf_wr_o), 32'd11);
        check("pushpop rf_wdata", bus.rf_wdata_o, 32'hB1);
        check("pushpop pend", bus.pend_o, 32'h800);
        cyc();
        set_lu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("pushpop next rf_wr", 32'(bus.rf_wr_o), 32'd12);
        check("pushpop next rf_wdata", bus.rf_wdata_o, 32'hC2);
        check("pushpop next pend", bus.pend_o, 32'h1000);
        cyc();
        @(negedge clk);
        check("final pend", bus.pend_o, 32'd0);
        check("final rf_we", 32'(bus.rf_we_o), 32'd0);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
